// File: rtl/gui_pkg.sv
// gui_pkg -- shared definitions for the GUI sequencer slice.
//   gui_state_t     : sequencer state encoding
//   gui_sel_t       : datapath select bundle decoded from the state
//   GUI_NUM_PIXELS  : pixels per full-screen fill (GUI_SCREEN_W x GUI_SCREEN_H)
//   gui_decode()    : state -> select lines (flash is handled by the top,
//                     since it only exists when GUI_FLASH_EN is defined)
package gui_pkg;

  localparam int unsigned GUI_SCREEN_W   = 160;
  localparam int unsigned GUI_SCREEN_H   = 120;
  localparam int unsigned GUI_NUM_PIXELS = GUI_SCREEN_W * GUI_SCREEN_H;

  typedef enum logic [2:0] {
    DRAW_TITLE,
    WAIT_START,
    DRAW_MAP,
    PLAY,
    FLASH_RED,
    FLASH_BLACK,
    DRAW_GAMEOVER,
    WAIT_RESTART
  } gui_state_t;

  typedef struct packed {
    logic title;
    logic map;
    logic gameover;
    logic active;
  } gui_sel_t;

  // FLASH_BLACK repaints the map, so it shares the map select.
  function automatic gui_sel_t gui_decode(input gui_state_t s);
    gui_sel_t o;
    o = '0;
    case (s)
      DRAW_TITLE:             o.title    = 1'b1;
      DRAW_MAP, FLASH_BLACK:  o.map      = 1'b1;
      DRAW_GAMEOVER:          o.gameover = 1'b1;
      PLAY:                   o.active   = 1'b1;
      default:                o          = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/gui_pixel_counter.sv
// gui_pixel_counter -- pixel address counter for one full-screen fill.
//   clk      : system clock, rising edge
//   enable   : count this cycle (plot high)
//   clear    : synchronous clear to pixel 0 (driven by the sequencer reset)
//   fillDone : high on the last pixel cycle of a fill while enabled
module gui_pixel_counter
  import gui_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = GUI_NUM_PIXELS
) (
  input  logic clk,
  input  logic enable,
  input  logic clear,
  output logic fillDone
);

  localparam int unsigned W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [W-1:0] LAST = W'(NUM_PIXELS - 1);

  logic [W-1:0] r_count;
  logic         w_last;

  assign w_last   = (r_count == LAST);
  assign fillDone = enable & w_last;

  // Wrapping at LAST leaves the counter at 0 for whichever fill follows.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_last ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/gui_sequencer.sv
// gui_sequencer -- screen sequencing FSM for the game GUI.
//   clk          : system clock, rising edge
//   reset        : synchronous active-high reset
//   start        : raw start/restart key (rising edge consumed in wait states)
//   gameOver     : collision indication, consumed only in PLAY
//   showTitle / showMap / showGameOver / flash : datapath select lines
//   plot         : VGA write enable, high while any fill runs
//   gameActive   : high only in PLAY
//   fillDone     : one-cycle pulse on the last pixel of a fill
// Build option: define GUI_FLASH_EN to insert FLASH_REPEATS red/black flash
// pairs between PLAY and DRAW_GAMEOVER; otherwise flash is tied 0.
module gui_sequencer
  import gui_pkg::*;
#(
  parameter int unsigned NUM_PIXELS    = GUI_NUM_PIXELS,
  parameter int unsigned FLASH_REPEATS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic gameOver,
  output logic showTitle,
  output logic showMap,
  output logic showGameOver,
  output logic flash,
  output logic plot,
  output logic gameActive,
  output logic fillDone
);

  gui_state_t r_state;
  gui_sel_t   r_sel;
  logic       r_start_q;
  logic       w_start_rise;
  logic       w_fill_done;
  logic       w_flash;

`ifdef GUI_FLASH_EN
  localparam int unsigned PAIR_W = $clog2(FLASH_REPEATS + 1);
  logic [PAIR_W-1:0] r_pairs;
  logic              r_flash;
  assign w_flash = r_flash;
`else
  assign w_flash = 1'b0;
`endif

  assign w_start_rise = start & ~r_start_q;

  assign showTitle    = r_sel.title;
  assign showMap      = r_sel.map;
  assign showGameOver = r_sel.gameover;
  assign gameActive   = r_sel.active;
  assign flash        = w_flash;
  assign plot         = r_sel.title | r_sel.map | r_sel.gameover | w_flash;
  assign fillDone     = w_fill_done;

  gui_pixel_counter #(
    .NUM_PIXELS (NUM_PIXELS)
  ) u_pixel_counter (
    .clk      (clk),
    .enable   (plot),
    .clear    (reset),
    .fillDone (w_fill_done)
  );

  // Select lines are registered together with the state they decode, so
  // every transition loads gui_decode() of its destination state.
  always_ff @(posedge clk) begin
    r_start_q <= start;
    if (reset) begin
      r_state   <= DRAW_TITLE;
      r_sel     <= gui_decode(DRAW_TITLE);
      r_start_q <= 1'b1;
`ifdef GUI_FLASH_EN
      r_pairs   <= '0;
      r_flash   <= 1'b0;
`endif
    end else begin
      case (r_state)
        DRAW_TITLE: if (w_fill_done) begin
          r_state <= WAIT_START;
          r_sel   <= gui_decode(WAIT_START);
        end
        WAIT_START: if (w_start_rise) begin
          r_state <= DRAW_MAP;
          r_sel   <= gui_decode(DRAW_MAP);
        end
        DRAW_MAP: if (w_fill_done) begin
          r_state <= PLAY;
          r_sel   <= gui_decode(PLAY);
        end
        PLAY: if (gameOver) begin
`ifdef GUI_FLASH_EN
          r_state <= FLASH_RED;
          r_sel   <= gui_decode(FLASH_RED);
          r_flash <= 1'b1;
          r_pairs <= '0;
`else
          r_state <= DRAW_GAMEOVER;
          r_sel   <= gui_decode(DRAW_GAMEOVER);
`endif
        end
`ifdef GUI_FLASH_EN
        FLASH_RED: if (w_fill_done) begin
          r_state <= FLASH_BLACK;
          r_sel   <= gui_decode(FLASH_BLACK);
          r_flash <= 1'b0;
        end
        FLASH_BLACK: if (w_fill_done) begin
          r_pairs <= r_pairs + PAIR_W'(1);
          if (r_pairs == PAIR_W'(FLASH_REPEATS - 1)) begin
            r_state <= DRAW_GAMEOVER;
            r_sel   <= gui_decode(DRAW_GAMEOVER);
          end else begin
            r_state <= FLASH_RED;
            r_sel   <= gui_decode(FLASH_RED);
            r_flash <= 1'b1;
          end
        end
`endif
        DRAW_GAMEOVER: if (w_fill_done) begin
          r_state <= WAIT_RESTART;
          r_sel   <= gui_decode(WAIT_RESTART);
        end
        WAIT_RESTART: if (w_start_rise) begin
          r_state <= DRAW_TITLE;
          r_sel   <= gui_decode(DRAW_TITLE);
        end
        default: begin
          r_state <= DRAW_TITLE;
          r_sel   <= gui_decode(DRAW_TITLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gui_sequencer.sv
// tb_gui_sequencer -- randomized directed bench for gui_sequencer.
// Uses a reduced NUM_PIXELS so complete game rounds fit in a short run.
// Expected outputs come from the screen sequence: each fill is NP cycles of
// one select line with plot high and fillDone on the last cycle; wait states
// end on a start rise (PLAY on gameOver).
module tb_gui_sequencer;

  localparam int unsigned NP = 100;
  localparam int unsigned FR = 3;

  typedef enum {K_TITLE, K_MAP, K_GAMEOVER, K_RED, K_BLACK} kind_t;

  logic clk = 1'b0;
  logic reset, start, gameOver;
  logic showTitle, showMap, showGameOver, flash, plot, gameActive, fillDone;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic        prev_start;

  always #5 clk = ~clk;

  gui_sequencer #(
    .NUM_PIXELS    (NP),
    .FLASH_REPEATS (FR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .gameOver     (gameOver),
    .showTitle    (showTitle),
    .showMap      (showMap),
    .showGameOver (showGameOver),
    .flash        (flash),
    .plot         (plot),
    .gameActive   (gameActive),
    .fillDone     (fillDone)
  );

  // {title, map, gameover, flash, plot, active, done}
  function automatic logic [6:0] ev(bit t, bit m, bit g, bit f, bit a, bit d);
    return {t, m, g, f, (t | m | g | f), a, d};
  endfunction

  function automatic logic [6:0] ev_kind(kind_t k, bit d);
    case (k)
      K_TITLE:    return ev(1, 0, 0, 0, 0, d);
      K_MAP:      return ev(0, 1, 0, 0, 0, d);
      K_GAMEOVER: return ev(0, 0, 1, 0, 0, d);
      K_RED:      return ev(0, 0, 0, 1, 0, d);
      default:    return ev(0, 1, 0, 0, 0, d);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {showTitle, showMap, showGameOver, flash, plot, gameActive, fillDone};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (title map gameover flash plot active done)",
             tag, obs, exp);
    end
  endtask

  // Apply inputs for the next rising edge, then move to the following negedge.
  task automatic step(input logic s, input logic g);
    start    = s;
    gameOver = g;
    @(negedge clk);
    prev_start = s;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    start    = 1'($urandom_range(0, 1));
    gameOver = 1'($urandom_range(0, 1));
    @(negedge clk);
    reset      = 1'b0;
    prev_start = 1'b1;
  endtask

  // Checks n cycles of a fill; start is held high from index hold_from on.
  task automatic fill(input string tag, input kind_t k, input int unsigned n,
                      input int unsigned hold_from);
    logic s, g;
    for (int unsigned i = 0; i < n; i++) begin
      chk(tag, ev_kind(k, i == NP - 1));
      s = (i >= hold_from) ? 1'b1 : 1'($urandom_range(0, 1));
      g = (i == NP - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      step(s, g);
    end
  endtask

  // Idle wait: leaves on a start rise (or gameOver in PLAY); forced by maxc.
  task automatic wait_idle(input string tag, input bit is_play, input int unsigned maxc);
    logic s, g;
    bit   fire;
    for (int unsigned c = 0; c <= maxc; c++) begin
      chk(tag, ev(0, 0, 0, 0, is_play, 0));
      if (is_play) begin
        s    = 1'($urandom_range(0, 1));
        g    = (c == maxc) || ($urandom_range(0, 15) == 0);
        fire = g;
      end else begin
        g = 1'($urandom_range(0, 1));
        if (c == maxc)          s = 1'b1;
        else if (c + 1 == maxc) s = 1'b0;
        else                    s = 1'($urandom_range(0, 1));
        fire = s & ~prev_start;
      end
      step(s, g);
      if (fire) return;
    end
  endtask

  task automatic game_over_seq();
`ifdef GUI_FLASH_EN
    for (int unsigned p = 0; p < FR; p++) begin
      fill("flash_red", K_RED, NP, NP);
      fill("flash_black", K_BLACK, NP, NP);
    end
`endif
    fill("gameover_fill", K_GAMEOVER, NP, NP);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    gameOver   = 1'b0;
    prev_start = 1'b1;

    // Power-up: two reset cycles, then a full title fill.
    @(negedge clk);
    chk("reset_state", ev(1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset      = 1'b0;
    prev_start = 1'b1;
    fill("title_powerup", K_TITLE, NP, NP / 2);

    // Key held from inside the title fill: no advance in WAIT_START.
    for (int unsigned c = 0; c < 100; c++) begin
      chk("start_held", ev(0, 0, 0, 0, 0, 0));
      step(1'b1, 1'($urandom_range(0, 1)));
    end
    chk("start_drop", ev(0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1);
    chk("start_low", ev(0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b0);

    // Round 1: map, play, game over, restart.
    fill("map_fill", K_MAP, NP, NP);
    wait_idle("play", 1'b1, $urandom_range(3, 40));
    game_over_seq();
    wait_idle("wait_restart", 1'b0, $urandom_range(2, 30));

    // Round 2: reset in the middle of the map fill.
    fill("title_round2", K_TITLE, NP, NP);
    wait_idle("wait_start", 1'b0, $urandom_range(2, 30));
    fill("map_partial", K_MAP, NP / 2, NP);
    do_reset();
    fill("title_after_reset", K_TITLE, NP, NP);

    // Round 3: full game, then reset in the middle of the game-over path.
    wait_idle("wait_start", 1'b0, $urandom_range(2, 30));
    fill("map_fill", K_MAP, NP, NP);
    wait_idle("play", 1'b1, $urandom_range(3, 40));
`ifdef GUI_FLASH_EN
    fill("flash_red_partial", K_RED, $urandom_range(1, NP - 2), NP);
`else
    fill("gameover_partial", K_GAMEOVER, $urandom_range(1, NP - 2), NP);
`endif
    do_reset();
    fill("title_after_reset2", K_TITLE, NP, NP);

    // Round 4: one more full randomized round.
    wait_idle("wait_start", 1'b0, $urandom_range(2, 30));
    fill("map_fill", K_MAP, NP, NP);
    wait_idle("play", 1'b1, $urandom_range(3, 40));
    game_over_seq();
    wait_idle("wait_restart", 1'b0, $urandom_range(2, 30));
    chk("title_reentry", ev(1, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gui_sequencer.md
GUI_SEQUENCER -- requirements
Module: gui_sequencer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 19200, meaning pixels per full-screen fill (160x120).
REQ-002 SHALL have parameter FLASH_REPEATS, default 3, meaning red/black flash pairs on game over.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, level start/restart key; raw, not edge-cleaned.
REQ-006 SHALL have port gameOver, input, 1, collision indication from game logic.
REQ-007 SHALL have ports showTitle, showMap, showGameOver and flash, output, 1 each, datapath select lines.
REQ-008 SHALL have port plot, output, 1, VGA write enable, high while any fill is in progress.
REQ-009 SHALL have port gameActive, output, 1, high only while gameplay runs.
REQ-010 SHALL have port fillDone, output, 1, one-cycle pulse on the last pixel cycle of a fill.

Function
REQ-011 SHALL use states DRAW_TITLE, WAIT_START, DRAW_MAP, PLAY, FLASH_RED, FLASH_BLACK, DRAW_GAMEOVER and WAIT_RESTART.
REQ-012 SHALL decode all outputs from the state register only (Moore): DRAW_TITLE->showTitle, DRAW_MAP->showMap, DRAW_GAMEOVER->showGameOver, FLASH_RED->flash, FLASH_BLACK->showMap, PLAY->gameActive.
REQ-013 SHALL assert plot exactly when one of showTitle, showMap, showGameOver or flash is high; no two of these four are ever high together.
REQ-014 SHALL run a pixel counter, width ceil(log2(NUM_PIXELS)), that increments every cycle plot is high and wraps from NUM_PIXELS-1 to 0.
REQ-015 SHALL pulse fillDone when the counter equals NUM_PIXELS-1 with plot high; each fill therefore lasts exactly NUM_PIXELS cycles.
REQ-016 SHALL leave each fill state on the cycle after fillDone, with the counter at 0 on entry to the next state.
REQ-017 SHALL use transitions: DRAW_TITLE->WAIT_START; WAIT_START->DRAW_MAP on start rise; DRAW_MAP->PLAY; PLAY->FLASH_RED on gameOver high.
REQ-018 SHALL continue with FLASH_RED->FLASH_BLACK, then FLASH_BLACK->FLASH_RED until FLASH_REPEATS pairs complete, then ->DRAW_GAMEOVER.
REQ-019 SHALL continue with DRAW_GAMEOVER->WAIT_RESTART and WAIT_RESTART->DRAW_TITLE on start rise.
REQ-020 SHALL detect a start rise with a registered copy of start (start high, previous sample low); a held key SHALL NOT advance more than one state.
REQ-021 SHALL ignore start and gameOver in every state except the states that consume them.
REQ-022 SHALL have the start edge register track start in every state, so a key held through a fill does not fire on fill exit.
REQ-023 SHALL use a flash-pair counter of width ceil(log2(FLASH_REPEATS+1)), cleared on PLAY exit and incremented on each FLASH_BLACK fillDone.

Reset
REQ-024 SHALL, with reset high, go to state DRAW_TITLE with pixel counter 0, flash-pair counter 0 and start edge register 1 on the next edge.
REQ-025 SHALL drive outputs during and after reset as follows: showTitle=1, plot=1, all other outputs 0, fillDone=0.
REQ-026 SHALL treat reset mid-fill or mid-flash like power-up: abandon the fill and restart title from pixel 0.
REQ-027 SHALL require system integration to reset the datapath address in the same cycle, so counters stay aligned.

Configuration
REQ-028 SHALL support macro GUI_FLASH_EN: defined, the flash sequence per REQ-018 applies.
REQ-029 SHALL, with GUI_FLASH_EN undefined, go PLAY->DRAW_GAMEOVER directly; the FLASH states and flash-pair counter are absent and flash is tied 0.

Structure
REQ-030 SHALL take the state encoding typedef, NUM_PIXELS default, screen width 160 and height 120 from a shared package gui_pkg.
REQ-031 SHALL have one sub-module, gui_pixel_counter, holding the pixel counter and fillDone (parameter NUM_PIXELS; inputs enable and clear).

Verification
REQ-032 SHALL check power-up: reset 1 for 2 cycles, then release -> showTitle and plot high for exactly 19200 cycles, fillDone pulse on cycle 19200, then WAIT_START with plot 0.
REQ-033 SHALL check start held: start held high from inside the title fill through 100 cycles of WAIT_START -> no transition; drop then raise start -> DRAW_MAP next cycle.
REQ-034 SHALL check game over with GUI_FLASH_EN: gameOver pulse in PLAY -> 3 red and 3 black fills of 19200 cycles each, alternating, then showGameOver for 19200 cycles, then WAIT_RESTART.
REQ-035 SHALL check game over without GUI_FLASH_EN: same stimulus -> DRAW_GAMEOVER next cycle and flash never asserted.
REQ-036 SHALL check reset mid-fill: reset at pixel 5000 of DRAW_MAP -> DRAW_TITLE next cycle, counter 0, full 19200-cycle title fill.
REQ-037 SHALL check ignored inputs: gameOver asserted during DRAW_MAP and WAIT_START -> no state change.
